alu_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the shared 16-bit ALU.

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one shared ALU.
// Each op runs IDLE -> EXEC -> RESP and returns the result over valid/ready.
module alu_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [6:0]        req0_cmd,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [6:0]        req1_cmd,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_ofl,
    output logic              rsp_z,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_inva,
    output logic              alu_invb,
    output logic              alu_cin,
    output logic              alu_sign,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ofl,
    input  logic              alu_z,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              owner_last_q, owner_last_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              ofl_q, ofl_d;
    logic              z_q, z_d;

    logic gnt0, gnt1, rsp_hs;

    // On a tie the requester that did not own the last op wins.
    assign gnt0 = req0_valid & (~req1_valid | owner_last_q);
    assign gnt1 = req1_valid & (~req0_valid | ~owner_last_q);
    assign rsp_hs = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        owner_last_d = owner_last_q;
        a_d          = a_q;
        b_d          = b_q;
        cmd_d        = cmd_q;
        out_d        = out_q;
        ofl_d        = ofl_q;
        z_d          = z_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt0) begin
                    req0_ready = 1'b1;
                    a_d        = req0_a;
                    b_d        = req0_b;
                    cmd_d      = req0_cmd;
                    owner_d    = 1'b0;
                    state_d    = EXEC;
                end else if (gnt1) begin
                    req1_ready = 1'b1;
                    a_d        = req1_a;
                    b_d        = req1_b;
                    cmd_d      = req1_cmd;
                    owner_d    = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                out_d   = alu_out;
                ofl_d   = alu_ofl;
                z_d     = alu_z;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    owner_last_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            owner_last_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            cmd_q        <= '0;
            out_q        <= '0;
            ofl_q        <= 1'b0;
            z_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            owner_last_q <= owner_last_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cmd_q        <= cmd_d;
            out_q        <= out_d;
            ofl_q        <= ofl_d;
            z_q          <= z_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) & owner_q;
    assign rsp_out    = out_q;
    assign rsp_ofl    = ofl_q;
    assign rsp_z      = z_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = cmd_q[6:4];
    assign alu_inva   = cmd_q[3];
    assign alu_invb   = cmd_q[2];
    assign alu_cin    = cmd_q[1];
    assign alu_sign   = cmd_q[0];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stand-in, transaction-level model checked
// every cycle, plus directed ops with hand-computed results.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [6:0]  req0_cmd, req1_cmd;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_out;
    logic        rsp_ofl, rsp_z;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_inva, alu_invb, alu_cin, alu_sign, alu_ofl, alu_z;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_ofl(rsp_ofl), .rsp_z(rsp_z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_inva(alu_inva), .alu_invb(alu_invb),
        .alu_cin(alu_cin), .alu_sign(alu_sign),
        .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_z(alu_z),
        .busy(busy)
    );

    // ALU behaviour: op 000 add, 001 or, 010 xor, 011 and, else pass A.
    function automatic logic [17:0] alu_f(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [6:0] c);
        logic [15:0] x, y, r;
        logic [16:0] s;
        logic        of;
        x  = c[3] ? ~a : a;
        y  = c[2] ? ~b : b;
        s  = {1'b0, x} + {1'b0, y} + {16'd0, c[1]};
        of = 1'b0;
        case (c[6:4])
            3'b000: begin
                r  = s[15:0];
                of = c[0] ? ((x[15] == y[15]) && (r[15] != x[15])) : s[16];
            end
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = x & y;
            default: r = x;
        endcase
        return {r, of, (r == 16'd0)};
    endfunction

    always_comb begin
        {alu_out, alu_ofl, alu_z} =
            alu_f(alu_a, alu_b, {alu_op, alu_inva, alu_invb, alu_cin, alu_sign});
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Transaction model: age -1 = no op, 1 = executing, 2 = result pending.
    bit          model_ok = 0;
    int          age, who, last, g;
    logic [15:0] e_a, e_b, e_out;
    logic [6:0]  e_cmd;
    logic        e_ofl, e_z;
    logic [17:0] res;

    always @(negedge clk) begin
        g = -1;
        if (model_ok && age < 0) begin
            if (req0_valid && req1_valid) g = (last == 1) ? 0 : 1;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        if (model_ok) begin
            chk("busy", busy, age > 0);
            chk("req0_ready", req0_ready, g == 0);
            chk("req1_ready", req1_ready, g == 1);
            chk("both_ready", req0_ready & req1_ready, 0);
            chk("rsp0_valid", rsp0_valid, age == 2 && who == 0);
            chk("rsp1_valid", rsp1_valid, age == 2 && who == 1);
            chk("rsp_data", {rsp_out, rsp_ofl, rsp_z}, {e_out, e_ofl, e_z});
            chk("alu_pins",
                {alu_a, alu_b, alu_op, alu_inva, alu_invb, alu_cin, alu_sign},
                {e_a, e_b, e_cmd});
        end
        if (rst) begin
            model_ok = 1;
            age = -1; who = 0; last = 1;
            e_a = 0; e_b = 0; e_cmd = 0;
            e_out = 0; e_ofl = 0; e_z = 0;
        end else if (model_ok) begin
            if (age < 0) begin
                if (g == 0) begin
                    age = 1; who = 0;
                    e_a = req0_a; e_b = req0_b; e_cmd = req0_cmd;
                end else if (g == 1) begin
                    age = 1; who = 1;
                    e_a = req1_a; e_b = req1_b; e_cmd = req1_cmd;
                end
            end else if (age == 1) begin
                res = alu_f(e_a, e_b, e_cmd);
                {e_out, e_ofl, e_z} = res;
                age = 2;
            end else if ((who == 0) ? rsp0_ready : rsp1_ready) begin
                last = who;
                age  = -1;
            end
        end
    end

    int glog[$];
    always @(negedge clk) begin
        if (req0_valid && req0_ready) glog.push_back(0);
        if (req1_valid && req1_ready) glog.push_back(1);
    end

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run_op(input int n, input logic [15:0] a,
                          input logic [15:0] b, input logic [6:0] c,
                          output logic [15:0] o, output logic of,
                          output logic zz, output logic other_v);
        int  t;
        bit  got;
        @(posedge clk); #1;
        if (n == 0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_cmd = c;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_cmd = c;
        end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) got = 1;
        end
        t = cyc;
        chk("grant_seen", got, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((n == 0) ? rsp0_valid : rsp1_valid) got = 1;
        end
        chk("rsp_seen", got, 1);
        chk("latency", cyc - t, 2);
        o = rsp_out; of = rsp_ofl; zz = rsp_z;
        other_v = (n == 0) ? rsp1_valid : rsp0_valid;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    logic [15:0] o, held_a;
    logic        of, zz, ov;
    bit          got;
    int          exp_g [4];

    initial begin
        rst = 1; req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_cmd = 0;
        req1_a = 0; req1_b = 0; req1_cmd = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_out", rsp_out, 16'h0000);
        chk("reset_alu_a", alu_a, 16'h0000);

        // add with signed overflow
        run_op(0, 16'h7FFF, 16'h0001, 7'b000_0001, o, of, zz, ov);
        chk("t1_out", o, 16'h8000);
        chk("t1_ofl", of, 1);
        chk("t1_z", zz, 0);
        chk("t1_rsp1_idle", ov, 0);

        // subtract to zero on requester 1
        run_op(1, 16'h0005, 16'h0005, 7'b000_0111, o, of, zz, ov);
        chk("t2_out", o, 16'h0000);
        chk("t2_z", zz, 1);
        chk("t2_ofl", of, 0);
        chk("t2_rsp0_idle", ov, 0);

        // logic AND
        run_op(0, 16'hF0F0, 16'h0FF0, 7'b011_0000, o, of, zz, ov);
        chk("t6_out", o, 16'h00F0);

        // fairness from reset with both requesters always valid
        pulse_rst();
        glog.delete();
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 16'h0010; req0_b = 16'h0001; req0_cmd = 0;
        req1_valid = 1; req1_a = 16'h0020; req1_b = 16'h0002; req1_cmd = 0;
        for (int i = 0; i < 100 && glog.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        chk("fair_drain", got, 1);
        chk("fair_count", glog.size(), 4);
        exp_g = '{0, 1, 0, 1};
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk($sformatf("fair_grant%0d", i), glog[i], exp_g[i]);

        // backpressure on requester 0 with requester 1 waiting
        @(posedge clk); #1;
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h0101; req0_cmd = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1;
        end
        chk("bp_grant", got, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_a = 16'h0003; req1_b = 16'h0004; req1_cmd = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp0_valid) got = 1;
        end
        chk("bp_rsp", got, 1);
        held_a = alu_a;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_out", rsp_out, 16'h1335);
            chk("bp_alu_a", held_a, 16'h1234);
            chk("bp_alu_a_hold", alu_a, 16'h1234);
            chk("bp_busy", busy, 1);
            chk("bp_no_grant", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1; req1_valid = 0;
        @(negedge clk);
        chk("bp_last_resp", rsp0_valid, 1);
        @(negedge clk);
        chk("bp_idle", busy, 0);

        // reset while an op is executing
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 16'hAAAA; req0_b = 16'h1111; req0_cmd = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1;
        end
        chk("mid_grant", got, 1);
        @(posedge clk); #1;
        req0_valid = 0; rst = 1;
        @(negedge clk);
        chk("mid_exec_busy", busy, 1);
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_rsp0", rsp0_valid, 0);
        chk("mid_rsp1", rsp1_valid, 0);
        chk("mid_out", rsp_out, 16'h0000);
        @(posedge clk); #1 rst = 0;
        run_op(0, 16'h0100, 16'h0023, 7'b001_0000, o, of, zz, ov);
        chk("post_rst_out", o, 16'h0123);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
